// File: rtl/multi_key_counter.sv
// -----------------------------------------------------------------------------
// multi_key_counter
//
// Purpose:
//   Multi-channel push-button front end. Each channel:
//     - synchronises an active-low asynchronous switch (two flops),
//     - debounces it (DB_CYCLES consecutive stable samples to accept a change),
//     - emits a one-cycle press tick on each accepted press, plus optional
//       auto-repeat ticks while held (IDLE -> DELAY -> REPEAT),
//     - counts press ticks mod MOD (cnt_db) and raw synchronised rising
//       edges mod MOD (cnt_raw), so contact bounce is visible.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   sw_n     [CH]   raw switches, active low, asynchronous to clk
//   clr      synchronous clear of every cnt_db / cnt_raw digit
//   rpt_en   auto-repeat enable, shared by all channels
//   level    [CH]   debounced pressed state (1 = pressed)
//   press    [CH]   one-cycle tick per accepted press or repeat
//   cnt_db   [4*CH] debounced press count, channel i in [4i+3:4i]
//   cnt_raw  [4*CH] undebounced rising-edge count, same packing
//
// Repeat FSM state per channel is held in g_ch[i].state (rpt_state_t) so it
// can be observed hierarchically.
// -----------------------------------------------------------------------------
module multi_key_counter #(
  parameter int CH           = 2,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int MOD          = 10,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sw_n,
  input  logic            clr,
  input  logic            rpt_en,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   press,
  output logic [4*CH-1:0] cnt_db,
  output logic [4*CH-1:0] cnt_raw
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W     = $clog2(DB_CYCLES);
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
  localparam logic [3:0]        DIGIT_LAST = 4'(MOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return (v == DIGIT_LAST) ? 4'd0 : v + 4'd1;
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic              s1, s2, s2_prev;
    logic              level_q, level_d, press_q;
    logic              level_nxt, rise, rpt_tick;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    rpt_state_t        state, state_nxt;
    logic [3:0]        db_digit, raw_digit;

    // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
    assign level_nxt = ((s2 != level_q) && (db_cnt == DB_LAST)) ? s2 : level_q;

    // Accepted press: level rose on the previous edge.
    assign rise = level_q & ~level_d;

    // Sync, debounce, press register and both counters.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        s2_prev   <= 1'b0;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        level_d   <= 1'b0;
        press_q   <= 1'b0;
        db_digit  <= 4'd0;
        raw_digit <= 4'd0;
      end else begin
        s1      <= ~sw_n[i];
        s2      <= s1;
        s2_prev <= s2;

        if (s2 == level_q || db_cnt == DB_LAST) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end

        level_q <= level_nxt;
        level_d <= level_q;
        press_q <= rise | rpt_tick;

        // clr wins over a simultaneous increment.
        if (clr) begin
          db_digit <= 4'd0;
        end else if (press_q) begin
          db_digit <= wrap_inc(db_digit);
        end

        if (clr) begin
          raw_digit <= 4'd0;
        end else if (s2 && !s2_prev) begin
          raw_digit <= wrap_inc(raw_digit);
        end
      end
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
      end
    end

    // Repeat FSM next state. Using level_nxt (not level_q) makes repeats stop
    // on the same edge that level falls.
    always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      rpt_tick  = 1'b0;
      if (!level_nxt || !rpt_en) begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state_nxt = DELAY;
              hold_nxt  = '0;
            end
          end
          DELAY: begin
            if (hold_cnt == DELAY_LAST) begin
              rpt_tick  = 1'b1;
              hold_nxt  = '0;
              state_nxt = REPEAT;
            end else begin
              hold_nxt = hold_cnt + HOLD_W'(1);
            end
          end
          REPEAT: begin
            if (hold_cnt == RATE_LAST) begin
              rpt_tick = 1'b1;
              hold_nxt = '0;
            end else begin
              hold_nxt = hold_cnt + HOLD_W'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        endcase
      end
    end

    assign level[i]           = level_q;
    assign press[i]           = press_q;
    assign cnt_db[4*i +: 4]   = db_digit;
    assign cnt_raw[4*i +: 4]  = raw_digit;
  end

endmodule

// File: tb/tb_multi_key_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_key_counter
//
// Bench for multi_key_counter with CH=2, DB_CYCLES=4, MOD=10, REPEAT_DELAY=10,
// REPEAT_RATE=3. A reference model (sample history window for debounce,
// age-since-press arithmetic for repeats, modular digits) pushes the expected
// outputs after every clock edge; a compare process pops and checks them on
// the falling edge. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_multi_key_counter;

  localparam int CH  = 2;
  localparam int DB  = 4;
  localparam int MOD = 10;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int W   = 10 * CH;

  // ---------------------------------------------------------------- clock/reset
  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            rpt_en;
  logic [CH-1:0]   sw_n;
  logic [CH-1:0]   level;
  logic [CH-1:0]   press;
  logic [4*CH-1:0] cnt_db;
  logic [4*CH-1:0] cnt_raw;

  always #5 clk = ~clk;

  multi_key_counter #(
    .CH(CH), .DB_CYCLES(DB), .MOD(MOD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .sw_n(sw_n), .clr(clr), .rpt_en(rpt_en),
    .level(level), .press(press), .cnt_db(cnt_db), .cnt_raw(cnt_raw)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [CH-1:0]   m_s1, m_s2, m_s2p, m_level, m_level_d, m_press;
  logic [4*CH-1:0] m_db, m_raw;
  logic [DB-1:0]   m_hist [CH];
  int              m_age [CH];
  bit              m_armed [CH];

  logic [CH-1:0]   n_level, n_press;
  logic [4*CH-1:0] n_db, n_raw;
  logic [DB-1:0]   n_hist [CH];
  int              n_age [CH];
  bit              n_armed [CH];
  int              md;
  bit              m_rise, m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_s1      <= '0;
      m_s2      <= '0;
      m_s2p     <= '0;
      m_level   <= '0;
      m_level_d <= '0;
      m_press   <= '0;
      m_db      <= '0;
      m_raw     <= '0;
      for (int c = 0; c < CH; c++) begin
        m_hist[c]  <= '0;
        m_age[c]   <= 0;
        m_armed[c] <= 1'b0;
      end
      exp_q.push_back('0);
    end else begin
      n_level = m_level;
      n_press = '0;
      n_db    = m_db;
      n_raw   = m_raw;
      for (int c = 0; c < CH; c++) begin
        // Raw rising edge of the synchronised switch.
        if (m_s2[c] && !m_s2p[c]) begin
          md = int'(m_raw[4*c +: 4]);
          n_raw[4*c +: 4] = 4'((md + 1) % MOD);
        end
        // Debounce: flip once the last DB samples all disagree with level.
        n_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
        if (n_hist[c] == {DB{!m_level[c]}}) n_level[c] = !m_level[c];
        // Repeat: ticks at ages RD, RD+RR, RD+2RR, ... after the press tick.
        m_rise     = m_level[c] && !m_level_d[c];
        m_tick     = 1'b0;
        n_armed[c] = m_armed[c];
        n_age[c]   = m_age[c];
        if (!n_level[c] || !rpt_en) begin
          n_armed[c] = 1'b0;
        end else if (m_rise) begin
          n_armed[c] = 1'b1;
          n_age[c]   = 0;
        end else if (m_armed[c]) begin
          n_age[c] = m_age[c] + 1;
          if (n_age[c] >= RD && ((n_age[c] - RD) % RR) == 0) m_tick = 1'b1;
        end
        n_press[c] = m_rise || m_tick;
        if (m_press[c]) begin
          md = int'(m_db[4*c +: 4]);
          n_db[4*c +: 4] = 4'((md + 1) % MOD);
        end
      end
      if (clr) begin
        n_db  = '0;
        n_raw = '0;
      end
      m_s1      <= ~sw_n;
      m_s2      <= m_s1;
      m_s2p     <= m_s2;
      m_level_d <= m_level;
      m_level   <= n_level;
      m_press   <= n_press;
      m_db      <= n_db;
      m_raw     <= n_raw;
      for (int c = 0; c < CH; c++) begin
        m_hist[c]  <= n_hist[c];
        m_age[c]   <= n_age[c];
        m_armed[c] <= n_armed[c];
      end
      exp_q.push_back({n_level, n_press, n_db, n_raw});
    end
  end

  // Compare process: one expected entry per clock edge.
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("level",   level,   e[W-1 -: CH]);
      check("press",   press,   e[W-CH-1 -: CH]);
      check("cnt_db",  cnt_db,  e[8*CH-1 -: 4*CH]);
      check("cnt_raw", cnt_raw, e[4*CH-1:0]);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  int tk;
  int np [CH];
  int lvl_at [CH];
  int ticks0[$];

  task automatic mark();
    tk = -1;
    for (int c = 0; c < CH; c++) begin
      np[c]     = 0;
      lvl_at[c] = -1;
    end
    ticks0.delete();
  endtask

  // Advance n cycles; tk is the index of the edge just taken since mark().
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      tk++;
      for (int c = 0; c < CH; c++) begin
        if (press[c]) np[c]++;
        if (level[c] && lvl_at[c] < 0) lvl_at[c] = tk;
      end
      if (press[0]) ticks0.push_back(tk);
    end
  endtask

  function automatic int tick_at(input int i);
    return (i < ticks0.size()) ? ticks0[i] : -1000;
  endfunction

  // ---------------------------------------------------------------- stimulus
  int  run [CH];
  bit  found;

  initial begin
    rst    = 1'b1;
    clr    = 1'b0;
    rpt_en = 1'b0;
    sw_n   = '1;
    mark();
    cyc(3);
    check("reset_level",   level,   0);
    check("reset_press",   press,   0);
    check("reset_cnt_db",  cnt_db,  0);
    check("reset_cnt_raw", cnt_raw, 0);
    rst = 1'b0;
    cyc(4);

    // Clean press/release on ch0 without repeat.
    rpt_en  = 1'b0;
    sw_n[0] = 1'b0;
    mark();
    cyc(14);
    sw_n[0] = 1'b1;
    cyc(12);
    check("clean_level_edge", lvl_at[0], 5);
    check("clean_press_edge", tick_at(0), 6);
    check("clean_press_cnt",  np[0], 1);
    check("clean_ch1_press",  np[1], 0);
    check("clean_cnt_db",     cnt_db, 8'h01);
    check("clean_cnt_raw",    cnt_raw, 8'h01);
    check("clean_released",   level, 0);

    // Bouncy press on ch1: five 2-cycle lows split by 1-cycle highs, last one held.
    mark();
    for (int k = 0; k < 4; k++) begin
      sw_n[1] = 1'b0;
      cyc(2);
      sw_n[1] = 1'b1;
      cyc(1);
    end
    sw_n[1] = 1'b0;
    cyc(16);
    sw_n[1] = 1'b1;
    cyc(12);
    check("bounce_raw",   cnt_raw[7:4], 5);
    check("bounce_db",    cnt_db[7:4],  1);
    check("bounce_press", np[1], 1);
    check("bounce_ch0",   np[0], 0);

    // Held press with repeat on ch0: 1 press + 7 repeats before level falls.
    clr = 1'b1;
    cyc(1);
    clr     = 1'b0;
    rpt_en  = 1'b1;
    sw_n[0] = 1'b0;
    mark();
    cyc(32);
    sw_n[0] = 1'b1;
    cyc(15);
    check("rpt_ticks",      np[0], 8);
    check("rpt_first_gap",  tick_at(1) - tick_at(0), RD);
    check("rpt_second_gap", tick_at(2) - tick_at(1), RR);
    check("rpt_last_gap",   tick_at(7) - tick_at(6), RR);
    check("rpt_cnt_db",     cnt_db[3:0], 8);
    check("rpt_released",   level[0], 0);

    // Two more clean presses: 8 -> 9 -> wraps to 0.
    rpt_en  = 1'b0;
    sw_n[0] = 1'b0;
    cyc(10);
    sw_n[0] = 1'b1;
    cyc(10);
    check("wrap_pre", cnt_db[3:0], 9);
    sw_n[0] = 1'b0;
    cyc(10);
    sw_n[0] = 1'b1;
    cyc(10);
    check("wrap_db",  cnt_db[3:0], 0);
    check("wrap_raw", cnt_raw[3:0], 3);

    // rpt_en dropped mid-REPEAT, re-enabled while still held.
    rpt_en  = 1'b1;
    sw_n[0] = 1'b0;
    mark();
    cyc(21);
    rpt_en = 1'b0;
    cyc(5);
    rpt_en = 1'b1;
    cyc(20);
    check("rpt_off_ticks", np[0], 3);
    sw_n[0] = 1'b1;
    cyc(10);
    sw_n[0] = 1'b0;
    mark();
    cyc(20);
    check("rpt_resume_ticks", np[0], 3);
    sw_n[0] = 1'b1;
    cyc(10);

    // clr in the same cycle as press[0].
    rpt_en  = 1'b0;
    sw_n[0] = 1'b0;
    mark();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1);
      if (press[0]) found = 1'b1;
    end
    check("clr_press_seen", found, 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_cnt_db",  cnt_db, 0);
    check("clr_cnt_raw", cnt_raw, 0);
    check("clr_level",   level[0], 1);
    cyc(2);
    check("clr_inc_lost", cnt_db, 0);
    sw_n[0] = 1'b1;
    cyc(10);

    // Asynchronous reset while ch0 is held and ch1 is mid-debounce.
    sw_n[0] = 1'b0;
    cyc(10);
    sw_n[1] = 1'b0;
    cyc(2);
    check("pre_rst_level",  level, 2'b01);
    check("pre_rst_cnt_db", cnt_db[3:0], 1);
    #1 rst = 1'b1;
    #1;
    check("rst_now_level",   level,   0);
    check("rst_now_press",   press,   0);
    check("rst_now_cnt_db",  cnt_db,  0);
    check("rst_now_cnt_raw", cnt_raw, 0);
    cyc(2);
    rst = 1'b0;
    mark();
    cyc(12);
    check("rst_requal_ch0", lvl_at[0], 5);
    check("rst_requal_ch1", lvl_at[1], 5);
    sw_n = '1;
    cyc(10);

    // Randomised phase.
    for (int c = 0; c < CH; c++) run[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (run[c] == 0) begin
          sw_n[c] = ~sw_n[c];
          run[c]  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
        end else begin
          run[c]--;
        end
      end
      if ($urandom_range(0, 99) < 3) rpt_en = ~rpt_en;
      clr = ($urandom_range(0, 99) < 2);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      cyc(1);
    end
    rst  = 1'b0;
    clr  = 1'b0;
    sw_n = '1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
